// File: rtl/demux4_burst_dispatcher.sv
// Steers a single valid/ready word stream, in order, to four output channels.
// A round-robin pointer moves to the next channel after every BURST accepted words.
module demux4_burst_dispatcher #(
   parameter int W     = 8,
   parameter int BURST = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic [3:0]   out_ready,
   output logic [3:0]   out_valid,
   output logic [W-1:0] out_data0,
   output logic [W-1:0] out_data1,
   output logic [W-1:0] out_data2,
   output logic [W-1:0] out_data3,
   output logic [1:0]   sel,
   output logic         busy
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  data_q, data_nx;
   logic [1:0]    dest_q, dest_nx;
   logic [1:0]    ptr_q, ptr_nx;
   logic [CW-1:0] cnt_q, cnt_nx;
   logic          full;
   logic          accept;
   logic          fire;

   assign full     = (state == FULL);
   assign fire     = full & out_ready[dest_q];
   assign in_ready = ~full | fire;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         data_q <= '0;
         dest_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nx;
         data_q <= data_nx;
         dest_q <= dest_nx;
         ptr_q  <= ptr_nx;
         cnt_q  <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      data_nx  = data_q;
      dest_nx  = dest_q;
      ptr_nx   = ptr_q;
      cnt_nx   = cnt_q;

      case (state)
         EMPTY: begin
            if (accept) begin
               state_nx = FULL;
               data_nx  = in_data;
               dest_nx  = ptr_q;
            end
         end
         FULL: begin
            if (fire && accept) begin
               data_nx = in_data;
               dest_nx = ptr_q;
            end else if (fire) begin
               state_nx = EMPTY;
            end
         end
      endcase

      if (accept) begin
         if (cnt_q == CNT_LAST) begin
            cnt_nx = '0;
            ptr_nx = ptr_q + 2'd1;
         end else begin
            cnt_nx = cnt_q + CW'(1);
         end
      end

      // Flush overrides everything above, including an accept in the same cycle.
      if (flush) begin
         state_nx = EMPTY;
         data_nx  = '0;
         ptr_nx   = '0;
         cnt_nx   = '0;
      end
   end

   assign out_valid[0] = full & (dest_q == 2'd0);
   assign out_valid[1] = full & (dest_q == 2'd1);
   assign out_valid[2] = full & (dest_q == 2'd2);
   assign out_valid[3] = full & (dest_q == 2'd3);

   assign out_data0 = out_valid[0] ? data_q : '0;
   assign out_data1 = out_valid[1] ? data_q : '0;
   assign out_data2 = out_valid[2] ? data_q : '0;
   assign out_data3 = out_valid[3] ? data_q : '0;

   assign sel  = ptr_q;
   assign busy = full;

endmodule

// File: tb/tb_demux4_burst_dispatcher.sv
// Directed, table-driven bench for demux4_burst_dispatcher (BURST=2 and BURST=1 instances).
// Each vector holds one cycle's inputs and the outputs expected just before the next rising edge.
module tb_demux4_burst_dispatcher;

   typedef struct {
      logic       fl;
      logic       iv;
      logic [7:0] id;
      logic [3:0] ordy;
      logic       e_rdy;
      logic [3:0] e_ov;
      logic [7:0] e_d;
      logic [1:0] e_sel;
      logic       e_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] out_ready;
   logic [3:0] out_valid;
   logic [7:0] out_data0, out_data1, out_data2, out_data3;
   logic [1:0] sel;
   logic       busy;

   logic       b1_flush;
   logic       b1_in_valid;
   logic [7:0] b1_in_data;
   logic       b1_in_ready;
   logic [3:0] b1_out_ready;
   logic [3:0] b1_out_valid;
   logic [7:0] b1_out_data0, b1_out_data1, b1_out_data2, b1_out_data3;
   logic [1:0] b1_sel;
   logic       b1_busy;

   int checks = 0;
   int passes = 0;
   vec_t vecs[$];

   demux4_burst_dispatcher #(.W(8), .BURST(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid(out_valid),
      .out_data0(out_data0), .out_data1(out_data1),
      .out_data2(out_data2), .out_data3(out_data3),
      .sel(sel), .busy(busy)
   );

   demux4_burst_dispatcher #(.W(8), .BURST(1)) dut1 (
      .clk(clk), .reset(reset), .flush(b1_flush),
      .in_valid(b1_in_valid), .in_data(b1_in_data), .in_ready(b1_in_ready),
      .out_ready(b1_out_ready), .out_valid(b1_out_valid),
      .out_data0(b1_out_data0), .out_data1(b1_out_data1),
      .out_data2(b1_out_data2), .out_data3(b1_out_data3),
      .sel(b1_sel), .busy(b1_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [39:0] exp_pack(input logic rdy, input logic [3:0] ov,
                                            input logic [7:0] d, input logic [1:0] s,
                                            input logic bsy);
      return {rdy, ov, ov[0] ? d : 8'h00, ov[1] ? d : 8'h00,
              ov[2] ? d : 8'h00, ov[3] ? d : 8'h00, s, bsy};
   endfunction

   function automatic logic [39:0] act_pack();
      return {in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, sel, busy};
   endfunction

   function automatic logic [39:0] act_pack_b1();
      return {b1_in_ready, b1_out_valid, b1_out_data0, b1_out_data1,
              b1_out_data2, b1_out_data3, b1_sel, b1_busy};
   endfunction

   task automatic add(input logic fl, input logic iv, input logic [7:0] id,
                      input logic [3:0] ordy, input logic rdy, input logic [3:0] ov,
                      input logic [7:0] d, input logic [1:0] s, input logic bsy);
      vec_t v;
      v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_rdy = rdy; v.e_ov = ov; v.e_d = d; v.e_sel = s; v.e_busy = bsy;
      vecs.push_back(v);
   endtask

   // Packed fields: {in_ready, out_valid, data0, data1, data2, data3, sel, busy}.
   task automatic check_output(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic apply_stimulus(input int idx);
      vec_t v;
      v = vecs[idx];
      @(negedge clk);
      flush     = v.fl;
      in_valid  = v.iv;
      in_data   = v.id;
      out_ready = v.ordy;
      #1;
      check_output($sformatf("vec%0d", idx), act_pack(),
                   exp_pack(v.e_rdy, v.e_ov, v.e_d, v.e_sel, v.e_busy));
   endtask

   initial begin
      int n_pre;
      logic [1:0] b1_dest [5];
      b1_dest[0] = 2'd0; b1_dest[1] = 2'd1; b1_dest[2] = 2'd2;
      b1_dest[3] = 2'd3; b1_dest[4] = 2'd0;

      // Streaming, all channels ready: two words per channel, pointer wraps.
      add(0,1,8'h11,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(0,1,8'h22,4'hF, 1,4'b0001,8'h11,2'd0,1);
      add(0,1,8'h33,4'hF, 1,4'b0001,8'h22,2'd1,1);
      add(0,1,8'h44,4'hF, 1,4'b0010,8'h33,2'd1,1);
      add(0,1,8'h55,4'hF, 1,4'b0010,8'h44,2'd2,1);
      add(0,1,8'h66,4'hF, 1,4'b0100,8'h55,2'd2,1);
      add(0,1,8'h77,4'hF, 1,4'b0100,8'h66,2'd3,1);
      add(0,1,8'h88,4'hF, 1,4'b1000,8'h77,2'd3,1);
      add(0,0,8'h00,4'hF, 1,4'b1000,8'h88,2'd0,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd0,0);
      // Backpressure on channel 1 while it holds 0x33.
      add(0,1,8'h11,4'hD, 1,4'b0000,8'h00,2'd0,0);
      add(0,1,8'h22,4'hD, 1,4'b0001,8'h11,2'd0,1);
      add(0,1,8'h33,4'hD, 1,4'b0001,8'h22,2'd1,1);
      for (int k = 0; k < 5; k++) add(0,1,8'h44,4'hD, 0,4'b0010,8'h33,2'd1,1);
      add(0,1,8'h44,4'hF, 1,4'b0010,8'h33,2'd1,1);
      add(0,0,8'h00,4'hF, 1,4'b0010,8'h44,2'd2,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd2,0);
      // Isolation: channel 2 holds 0xA5 while the other channels are ready.
      add(0,1,8'hA5,4'hB, 1,4'b0000,8'h00,2'd2,0);
      add(0,1,8'h5A,4'hB, 0,4'b0100,8'hA5,2'd2,1);
      add(0,1,8'h5A,4'hB, 0,4'b0100,8'hA5,2'd2,1);
      add(0,1,8'h5A,4'hF, 1,4'b0100,8'hA5,2'd2,1);
      add(0,0,8'h00,4'hF, 1,4'b0100,8'h5A,2'd3,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd3,0);
      // Idle flush clears the pointer.
      add(1,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd3,0);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd0,0);
      // Reach ptr=2, cnt=1 with the buffer full, then flush.
      add(0,1,8'h01,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(0,1,8'h02,4'hF, 1,4'b0001,8'h01,2'd0,1);
      add(0,1,8'h03,4'hF, 1,4'b0001,8'h02,2'd1,1);
      add(0,1,8'h04,4'hF, 1,4'b0010,8'h03,2'd1,1);
      add(0,1,8'h05,4'hB, 1,4'b0010,8'h04,2'd2,1);
      add(1,1,8'h06,4'hB, 0,4'b0100,8'h05,2'd2,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(0,1,8'h07,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(0,0,8'h00,4'hF, 1,4'b0001,8'h07,2'd0,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd0,0);
      // Flush with a concurrent fire and accept: the new word is dropped.
      add(0,1,8'h09,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(1,1,8'h0A,4'hF, 1,4'b0001,8'h09,2'd1,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd0,0);
      // Fill again so reset lands on a full buffer with ptr=1, cnt=1.
      add(0,1,8'h21,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(0,1,8'h22,4'hF, 1,4'b0001,8'h21,2'd0,1);
      add(0,1,8'h23,4'hF, 1,4'b0001,8'h22,2'd1,1);
      add(0,1,8'h24,4'h0, 0,4'b0010,8'h23,2'd1,1);
      n_pre = vecs.size();
      // After reset the next word goes to channel 0.
      add(0,1,8'h31,4'hF, 1,4'b0000,8'h00,2'd0,0);
      add(0,0,8'h00,4'hF, 1,4'b0001,8'h31,2'd0,1);
      add(0,0,8'h00,4'hF, 1,4'b0000,8'h00,2'd0,0);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'hF;
      b1_flush = 1'b0; b1_in_valid = 1'b0; b1_in_data = 8'h00; b1_out_ready = 4'hF;
      #1;
      check_output("reset_state", act_pack(), exp_pack(1,4'b0000,8'h00,2'd0,0));
      check_output("b1_reset_state", act_pack_b1(), exp_pack(1,4'b0000,8'h00,2'd0,0));
      @(negedge clk);
      #2 reset = 1'b0;

      for (int i = 0; i < n_pre; i++) apply_stimulus(i);

      #2 reset = 1'b1;
      in_valid = 1'b0;
      #1;
      check_output("reset_async_full", act_pack(), exp_pack(1,4'b0000,8'h00,2'd0,0));
      @(posedge clk);
      #1;
      check_output("reset_held", act_pack(), exp_pack(1,4'b0000,8'h00,2'd0,0));
      @(negedge clk);
      reset = 1'b0;
      out_ready = 4'hF;

      for (int i = n_pre; i < vecs.size(); i++) apply_stimulus(i);

      // BURST=1: every accept moves the pointer.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         b1_in_valid = 1'b1;
         b1_in_data  = 8'h40 + 8'(i);
         #1;
         check_output($sformatf("b1_push%0d", i), act_pack_b1(),
                      exp_pack(1, (i == 0) ? 4'b0000 : (4'b0001 << b1_dest[(i == 0) ? 0 : i-1]),
                               (i == 0) ? 8'h00 : 8'h40 + 8'(i-1), b1_dest[i], (i != 0)));
      end
      @(negedge clk);
      b1_in_valid = 1'b0;
      #1;
      check_output("b1_last", act_pack_b1(), exp_pack(1,4'b0001,8'h44,2'd1,1));
      @(negedge clk);
      #1;
      check_output("b1_drained", act_pack_b1(), exp_pack(1,4'b0000,8'h00,2'd1,0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/demux4_burst_dispatcher.md
Name: demux4_burst_dispatcher

Overview:
- Sequencing controller for the 4-way demultiplexer datapath: accepts a single valid/ready input word stream and steers it, in order, to four output channels.
- Channel selection is a round-robin pointer that advances after every BURST accepted words.
- One registered output stage holds each word until the destination channel accepts it.
- Unselected output data buses are driven to 0, so downstream logic sees exactly one live channel.
- Sits between a single producer and four per-lane consumers.

Parameters:
- W, 8, data width in bits.
- BURST, 4, words sent to one channel before the pointer advances; legal range 1..256.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of buffer and pointer; wins over all other activity.
- in_valid  input  1  producer has a word.
- in_data  input  W  producer word.
- in_ready  output  1  dispatcher can accept this cycle.
- out_ready  input  4  per-channel consumer ready, bit k = channel k.
- out_valid  output  4  per-channel valid; at most one bit high.
- out_data0..out_data3  output  W each  per-channel data; 0 when that channel is not valid.
- sel  output  2  channel that the next accepted word will go to.
- busy  output  1  output buffer is occupied.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - full=0, data register=0, dest=0, ptr=0, cnt=0.
  - Resulting outputs: out_valid=4'b0000, all out_data*=0, sel=0, busy=0, in_ready=1.
- Reset asserted mid-transfer discards the held word. Nothing is replayed.
- Definitions:
  - accept = in_valid & in_ready.
  - fire = full & out_ready[dest].
- in_ready = ~full | fire (combinational pass-through), giving 1 word/cycle sustained throughput.
- FSM, two states:
  - EMPTY (full=0):
    - accept → LOAD: data←in_data, dest←ptr → FULL.
    - Otherwise stay in EMPTY.
  - FULL (full=1):
    - fire & accept → reload data/dest, stay in FULL.
    - fire & ~accept → EMPTY.
    - ~fire → hold data and dest unchanged, ignore out_ready of other channels.
- Latency: a word accepted at edge N is presented (out_valid[dest]=1) from edge N through the edge where fire occurs. Minimum latency is 1 cycle.
- Output decode:
  - out_valid[k] = full & (dest==k).
  - out_data_k = data when out_valid[k], else 0.
  - Registered state, combinational decode.
- Pointer and burst counter, updated only on accept:
  - If cnt==BURST-1: cnt←0, ptr←ptr+1 (mod 4, 3 wraps to 0).
  - Otherwise cnt←cnt+1.
  - cnt width is $clog2(BURST) with a minimum of 1 bit. For BURST=1 the pointer advances on every accept.
  - sel = ptr.
- busy = full.
- In-order and blocking: a stalled channel stalls the whole stream. No skipping of not-ready channels.
- flush (synchronous, sampled at rising edge):
  - full←0, ptr←0, cnt←0, data←0.
  - An accept in the same cycle is dropped. in_ready is still computed normally, and the producer must not rely on acceptance while flush=1.
  - A concurrent fire completes from the consumer's view; the word is simply cleared.
- out_ready bits of non-selected channels have no effect.
- Out-of-protocol case: in_valid dropped without accept is permitted. State is unchanged.

Test Plan:
- Reset, no traffic: reset pulse mid-cycle, then idle → out_valid=0000, all out_data*=0, sel=0, in_ready=1, busy=0, checked immediately on reset assert (async).
- Streaming, BURST=2, all out_ready=1111: push 0x11,0x22,…,0x88 on consecutive cycles → channels 0,0,1,1,2,2,3,3 receive in order, one per cycle; sel wraps to 0 after 0x88; in_ready stays 1.
- Backpressure: BURST=2, out_ready[1]=0 while 0x33 targets channel 1 → out_valid=0010, out_data1=0x33 held, in_ready=0 for 5 cycles. Raise out_ready[1] → 0x33 fires the same cycle, next word 0x44 accepted that cycle.
- Isolation: while channel 2 holds 0xA5 with out_ready=1011 → out_data0/1/3=0, out_valid=0100, no word lost or duplicated after out_ready[2] rises.
- BURST=1 wrap: push 5 words → destinations 0,1,2,3,0; cnt never exceeds 0.
- Flush and reset mid-operation:
  - Flush with the buffer full and ptr=2,cnt=1 → next cycle out_valid=0000, sel=0. The next word goes to channel 0.
  - Reset asserted with the buffer full, same check.
